// File: rtl/iob_cache_arb_pkg.sv
// Shared constants for the iob cache arbiters: FSM state encoding and stats counter width.
package iob_cache_arb_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   localparam int ARB_CNT_W = 16;

endpackage

// File: rtl/iob_cache_rr_picker.sv
// Combinational rotate-priority encoder: first set request bit after i_last, wrapping around.
module iob_cache_rr_picker #(
   parameter int N_REQ = 4,
   parameter int REQ_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [REQ_W-1:0] i_last,
   output logic             o_found,
   output logic [REQ_W-1:0] o_idx
);

   int               w_cand;
   logic [REQ_W-1:0] w_sel;

   // Walk offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      w_cand  = 0;
      w_sel   = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         w_cand  = (int'(i_last) + i) % N_REQ;
         w_sel   = w_cand[REQ_W-1:0];
         o_found = o_found | i_req[w_sel];
         o_idx   = i_req[w_sel] ? w_sel : o_idx;
      end
   end

endmodule

// File: rtl/iob_cache_write_arbiter.sv
// Round-robin arbiter sharing one cache back-end write channel between N_REQ requesters.
// Optional per-requester completion counters under macro IOB_CACHE_ARB_STATS_EN.
module iob_cache_write_arbiter
   import iob_cache_arb_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int NBYTES = 4,
   parameter int REQ_W  = $clog2(N_REQ)
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [N_REQ-1:0]         req_valid_i,
   input  logic [N_REQ*ADDR_W-1:0]  req_addr_i,
   input  logic [N_REQ*DATA_W-1:0]  req_wdata_i,
   input  logic [N_REQ*NBYTES-1:0]  req_wstrb_i,
   output logic [N_REQ-1:0]         req_ready_o,
   output logic                     valid_o,
   output logic [ADDR_W-1:0]        addr_o,
   output logic [DATA_W-1:0]        wdata_o,
   output logic [NBYTES-1:0]        wstrb_o,
   input  logic                     ready_i,
   output logic [REQ_W-1:0]         grant_o,
`ifdef IOB_CACHE_ARB_STATS_EN
   input  logic                     stats_clr_i,
   output logic [N_REQ*ARB_CNT_W-1:0] grant_cnt_o,
`endif
   output logic                     busy_o
);

   arb_state_t       r_state, w_state_nxt;
   logic [REQ_W-1:0] r_grant, w_grant_nxt;
   logic [REQ_W-1:0] r_last, w_last_nxt;
   logic             w_found;
   logic [REQ_W-1:0] w_pick;
   logic             w_busy, w_valid, w_done, w_withdraw;

   logic [ADDR_W-1:0] w_addr  [N_REQ];
   logic [DATA_W-1:0] w_wdata [N_REQ];
   logic [NBYTES-1:0] w_wstrb [N_REQ];

   for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
      assign w_addr[k]  = req_addr_i[k*ADDR_W +: ADDR_W];
      assign w_wdata[k] = req_wdata_i[k*DATA_W +: DATA_W];
      assign w_wstrb[k] = req_wstrb_i[k*NBYTES +: NBYTES];
   end

   iob_cache_rr_picker #(.N_REQ(N_REQ), .REQ_W(REQ_W)) u_picker (
      .i_req   (req_valid_i),
      .i_last  (r_last),
      .o_found (w_found),
      .o_idx   (w_pick)
   );

   assign w_busy     = (r_state == ARB_BUSY);
   assign w_valid    = w_busy & req_valid_i[r_grant];
   assign w_done     = w_valid & ready_i;
   assign w_withdraw = w_busy & ~req_valid_i[r_grant];

   // State, grant owner and priority pointer registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= ARB_IDLE;
         r_grant <= '0;
         r_last  <= REQ_W'(N_REQ - 1);
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_last  <= w_last_nxt;
      end
   end

   // Grant is only loaded in IDLE, so it cannot move while BUSY.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_last_nxt  = r_last;
      case (r_state)
         ARB_IDLE: begin
            if (w_found) begin
               w_state_nxt = ARB_BUSY;
               w_grant_nxt = w_pick;
            end else begin
               w_state_nxt = ARB_IDLE;
            end
         end
         ARB_BUSY: begin
            if (w_done || w_withdraw) begin
               w_state_nxt = ARB_IDLE;
               w_last_nxt  = r_grant;
            end else begin
               w_state_nxt = ARB_BUSY;
            end
         end
         default: begin
            w_state_nxt = ARB_IDLE;
         end
      endcase
   end

   // Downstream handshake and payload mux; payload reads zero while idle.
   always_comb begin
      req_ready_o = '0;
      valid_o     = w_valid;
      busy_o      = w_busy;
      grant_o     = r_grant;
      if (w_done) begin
         req_ready_o[r_grant] = 1'b1;
      end else begin
         req_ready_o = '0;
      end
      if (w_busy) begin
         addr_o  = w_addr[r_grant];
         wdata_o = w_wdata[r_grant];
         wstrb_o = w_wstrb[r_grant];
      end else begin
         addr_o  = '0;
         wdata_o = '0;
         wstrb_o = '0;
      end
   end

`ifdef IOB_CACHE_ARB_STATS_EN
   logic [ARB_CNT_W-1:0] r_cnt [N_REQ];

   // Saturating completion counters; a clear wins over an increment.
   always_ff @(posedge clk_i) begin
      if (reset_i || stats_clr_i) begin
         for (int k = 0; k < N_REQ; k++) begin
            r_cnt[k] <= '0;
         end
      end else if (w_done && (r_cnt[r_grant] != {ARB_CNT_W{1'b1}})) begin
         r_cnt[r_grant] <= r_cnt[r_grant] + ARB_CNT_W'(1);
      end
   end

   for (genvar k = 0; k < N_REQ; k++) begin : g_cnt
      assign grant_cnt_o[k*ARB_CNT_W +: ARB_CNT_W] = r_cnt[k];
   end
`endif

endmodule
